// File: rtl/modmul_arbiter.sv
// Round-robin arbiter sharing one modular multiplier among N requesters.
// Latches the winner's operands, starts the multiplier, returns result + done.
`timescale 1ns/1ps
module modmul_arbiter #(
   parameter int N           = 4,
   parameter int W           = 256,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic [N-1:0]   i_req,
   input  logic [N*W-1:0] i_a,
   input  logic [N*W-1:0] i_b,
   input  logic [W-1:0]   i_p,
   output logic [N-1:0]   o_gnt,
   output logic [N-1:0]   o_done,
   output logic           o_err,
   output logic [W-1:0]   o_result,
   output logic           o_busy,
   output logic           mm_start,
   output logic [W-1:0]   mm_a,
   output logic [W-1:0]   mm_b,
   output logic [W-1:0]   mm_m,
   input  logic [W-1:0]   mm_p,
   input  logic           mm_ready
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(TIMEOUT_CYC) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] win;
   logic [PW-1:0] ptr_nxt;
   logic [N-1:0]  win_oh;
   logic          found;
   int            idx;
   logic          arm_q;
   logic [CW-1:0] cnt_q;
   logic          take;
   logic          complete;
   logic          expire;

   assign mm_m   = i_p;
   assign o_busy = (state_q != S_IDLE);

   // Scan ptr, ptr+1, ... wrapping; first requester found wins.
   always_comb begin
      win    = '0;
      found  = 1'b0;
      idx    = 0;
      win_oh = '0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr_q) + i) % N;
         if (!found && i_req[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
      win_oh[win] = 1'b1;
      ptr_nxt     = (int'(win) == N - 1) ? '0 : win + PW'(1);
   end

   always_comb begin
      state_d  = state_q;
      take     = 1'b0;
      complete = 1'b0;
      expire   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (|i_req) begin
               take    = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (arm_q && mm_ready) begin
               complete = 1'b1;
               state_d  = S_DONE;
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               expire  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ptr_q    <= '0;
         arm_q    <= 1'b0;
         cnt_q    <= '0;
         o_gnt    <= '0;
         o_done   <= '0;
         o_err    <= 1'b0;
         o_result <= '0;
         mm_start <= 1'b0;
         mm_a     <= '0;
         mm_b     <= '0;
      end else begin
         mm_start <= take;
         o_done   <= '0;
         o_err    <= 1'b0;
         if (take) begin
            o_gnt <= win_oh;
            ptr_q <= ptr_nxt;
            mm_a  <= i_a[int'(win)*W +: W];
            mm_b  <= i_b[int'(win)*W +: W];
            arm_q <= 1'b0;
            cnt_q <= '0;
         end
         // A ready seen before it has dropped once belongs to the last job.
         if (state_q == S_WAIT) begin
            cnt_q <= cnt_q + CW'(1);
            if (!mm_ready) arm_q <= 1'b1;
         end
         if (complete) begin
            o_result <= mm_p;
            o_done   <= o_gnt;
         end
         if (expire) begin
            o_result <= '0;
            o_done   <= o_gnt;
            o_err    <= 1'b1;
         end
         if (state_q == S_DONE) begin
            o_gnt    <= '0;
            o_result <= '0;
         end
      end
   end

endmodule

// File: tb/tb_modmul_arbiter.sv
// Bench for modmul_arbiter: directed requests, multiplier model, scoreboard.
`timescale 1ns/1ps
module tb_modmul_arbiter;

   localparam int N   = 4;
   localparam int W   = 256;
   localparam int W2  = 2 * W;
   localparam int TO  = 16;
   localparam int LAT = 5;
   localparam logic [W-1:0] P = (256'd1 << 255) - 256'd19;

   typedef struct {
      int         idx;
      logic [W-1:0] res;
      bit         err;
      int         lat;
   } exp_t;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] ia;
   logic [N*W-1:0] ib;
   logic [W-1:0]   p;
   logic [N-1:0]   gnt;
   logic [N-1:0]   done;
   logic           err;
   logic [W-1:0]   result;
   logic           busy;
   logic           mm_start;
   logic [W-1:0]   mm_a;
   logic [W-1:0]   mm_b;
   logic [W-1:0]   mm_m;
   logic [W-1:0]   mm_p = '0;
   logic           mm_ready = 1'b1;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_t = 0;
   int   n_starts = 0;
   int   mode = 0;

   logic [W-1:0] ma = '0;
   logic [W-1:0] mb = '0;
   int           mcnt = 0;
   bit           mbusy = 1'b0;

   modmul_arbiter #(.N(N), .W(W), .TIMEOUT_CYC(TO)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_req    (req),
      .i_a      (ia),
      .i_b      (ib),
      .i_p      (p),
      .o_gnt    (gnt),
      .o_done   (done),
      .o_err    (err),
      .o_result (result),
      .o_busy   (busy),
      .mm_start (mm_start),
      .mm_a     (mm_a),
      .mm_b     (mm_b),
      .mm_m     (mm_m),
      .mm_p     (mm_p),
      .mm_ready (mm_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] mulmod(logic [W-1:0] a, logic [W-1:0] b);
      logic [W2-1:0] t;
      t = W2'(a) * W2'(b);
      t = t % W2'(P);
      return t[W-1:0];
   endfunction

   // mode 0: normal, 1: stale ready lingers 2 cycles, 2: never ready
   always @(posedge clk) begin
      if (mm_start) begin
         mcnt  <= 0;
         mbusy <= 1'b1;
         ma    <= mm_a;
         mb    <= mm_b;
         if (mode != 1) mm_ready <= 1'b0;
      end else if (mbusy) begin
         mcnt <= mcnt + 1;
         if (mode == 1 && mcnt == 1) mm_ready <= 1'b0;
         if (mode != 2 && mcnt == LAT - 1) begin
            mm_ready <= 1'b1;
            mm_p     <= mulmod(ma, mb);
            mbusy    <= 1'b0;
         end
      end
   end

   task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t         e;
      logic [N-1:0] eoh;
      forever begin
         @(negedge clk);
         if (mm_start === 1'b1) begin
            start_t = cyc;
            n_starts++;
         end
         if (|done === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done act=%b exp=0", done);
            end else begin
               e = sbq.pop_front();
               eoh = '0;
               eoh[e.idx] = 1'b1;
               chk("done_onehot", W'(done), W'(eoh));
               chk("result", result, e.res);
               chk("err_flag", W'(err), W'(e.err));
               if (e.lat != 0)
                  chk("latency", W'(cyc - start_t), W'(e.lat));
            end
         end
      end
   end

   task automatic wait_gnt(int k);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (gnt[k] !== 1'b1 && n < 40);
      chk("grant_wait", W'(gnt[k]), W'(1));
   endtask

   task automatic wait_idle(int limit);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy !== 1'b0 || sbq.size() != 0) && n < limit);
      chk("idle_wait", W'(busy), W'(0));
   endtask

   task automatic wait_done(int limit, output logic [N-1:0] d);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (|done !== 1'b1 && n < limit);
      chk("done_wait", W'(|done), W'(1));
      d = done;
   endtask

   task automatic issue(int k, logic [W-1:0] a, logic [W-1:0] b,
                        logic [W-1:0] r, bit e, int lat, bit push);
      exp_t x;
      ia[k*W +: W] = a;
      ib[k*W +: W] = b;
      x.idx = k;
      x.res = r;
      x.err = e;
      x.lat = lat;
      if (push) sbq.push_back(x);
      req[k] = 1'b1;
      wait_gnt(k);
      req[k] = 1'b0;
   endtask

   task automatic push(int k, logic [W-1:0] r);
      exp_t x;
      x.idx = k;
      x.res = r;
      x.err = 1'b0;
      x.lat = 7;
      sbq.push_back(x);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_gnt"}, W'(gnt), W'(0));
      chk({tag, "_done"}, W'(done), W'(0));
      chk({tag, "_err"}, W'(err), W'(0));
      chk({tag, "_result"}, result, '0);
      chk({tag, "_busy"}, W'(busy), W'(0));
      chk({tag, "_start"}, W'(mm_start), W'(0));
   endtask

   initial begin : stim
      logic [N-1:0] d;
      rst_n = 1'b0;
      req   = '0;
      ia    = '0;
      ib    = '0;
      p     = P;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      chk("rst_mm_a", mm_a, '0);
      chk("rst_mm_b", mm_b, '0);
      chk("mm_m", mm_m, P);
      rst_n = 1'b1;

      // all four continuously requesting: order 0,1,2,3,0
      for (int k = 0; k < N; k++) begin
         ia[k*W +: W] = W'(10 + k);
         ib[k*W +: W] = W'(3);
      end
      push(0, 30);
      push(1, 33);
      push(2, 36);
      push(3, 39);
      push(0, 30);
      req = '1;
      for (int n = 0; n < 5; n++) begin
         wait_done(40, d);
         if (n == 4) req = '0;
         else req = req & ~d;
         @(negedge clk);
         if (n != 4) req = req | d;
      end
      wait_idle(100);

      issue(0, 3, 5, 15, 1'b0, 7, 1'b1);
      wait_idle(40);

      mode = 1;
      issue(1, 11, 13, 143, 1'b0, 7, 1'b1);
      wait_idle(40);
      mode = 0;

      issue(2, P - 256'd1, 2, P - 256'd2, 1'b0, 7, 1'b1);
      repeat (2) @(negedge clk);
      ia[2*W +: W] = W'(7);
      ib[2*W +: W] = W'(5);
      wait_idle(40);

      mode = 2;
      issue(3, 4, 4, '0, 1'b1, 17, 1'b1);
      wait_idle(60);
      mode = 0;

      // abandon an op in WAIT; ptr must restart at 0
      issue(1, 9, 9, '0, 1'b0, 0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("midrst");
      rst_n = 1'b1;
      ia[1*W +: W] = W'(21);
      ib[1*W +: W] = W'(2);
      ia[3*W +: W] = W'(1000);
      ib[3*W +: W] = W'(1000);
      push(1, 42);
      push(3, 1000000);
      req[1] = 1'b1;
      req[3] = 1'b1;
      wait_gnt(1);
      req[1] = 1'b0;
      wait_gnt(3);
      req[3] = 1'b0;
      wait_idle(100);

      chk("start_count", W'(n_starts), W'(12));
      chk("sb_empty", W'(sbq.size()), W'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
